// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store access stage in front of a word-addressed data memory.
//   Accepts byte-addressed byte/half/word requests, issues single-cycle
//   mem_read / mem_write strobes, extracts and extends load lanes, and
//   performs read-modify-write for sub-word stores. Misaligned or
//   illegal-size requests are answered with resp_misalign without any
//   memory access.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        load zero-extend when 1
//   req_addr            byte address
//   req_wdata           store data (byte/half from LSBs)
//   resp_valid          single-cycle completion pulse
//   resp_misalign       request rejected (with resp_valid)
//   resp_rdata          extended load data, 0 for stores/errors, held
//   mem_read/mem_write  memory strobes (never together)
//   mem_addr            word index of the latched byte address
//   mem_wdata           full word to write
//   mem_rdata           read data, valid the cycle after the mem_read edge
//
// WORD_W must be 32: byte lanes are fixed at four 8-bit lanes.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_misalign,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state_q,     state_d;
   logic                we_q,        we_d;
   logic [1:0]          size_q,      size_d;
   logic                uns_q,       uns_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [WORD_W-1:0]   wdata_q,     wdata_d;
   logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [WORD_W-1:0]   rdata_q,     rdata_d;

   // Size 11 is always illegal; halves need addr[0]=0, words addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      logic bad;
      case (sz)
         2'b00:   bad = 1'b0;
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Little-endian lane select followed by sign/zero extension.
   function automatic logic [WORD_W-1:0] load_extract(input logic [WORD_W-1:0] w,
                                                      input logic [1:0]        sz,
                                                      input logic [1:0]        off,
                                                      input logic              uns);
      logic [7:0]        b;
      logic [15:0]       h;
      logic [WORD_W-1:0] r;
      case (off)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   r = {{24{b[7] & ~uns}}, b};
         2'b01:   r = {{16{h[15] & ~uns}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Replace only the addressed byte/half of the word read back from memory.
   function automatic logic [WORD_W-1:0] store_merge(input logic [WORD_W-1:0] w,
                                                     input logic [1:0]        sz,
                                                     input logic [1:0]        off,
                                                     input logic [WORD_W-1:0] d);
      logic [WORD_W-1:0] r;
      r = w;
      case (sz)
         2'b00: begin
            case (off)
               2'b00:   r[7:0]   = d[7:0];
               2'b01:   r[15:8]  = d[7:0];
               2'b10:   r[23:16] = d[7:0];
               default: r[31:24] = d[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) r[31:16] = d[15:0];
            else        r[15:0]  = d[15:0];
         end
         default: r = d;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  state_d = S_ERR;
                  rdata_d = '0;
               end else if (req_we && (req_size == 2'b10)) begin
                  // Full-word stores need no read-back.
                  state_d     = S_WR;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD:   state_d = S_WAIT;
         S_WAIT: begin
            if (we_q) begin
               mem_wdata_d = store_merge(mem_rdata, size_q, addr_q[1:0], wdata_q);
               state_d     = S_WR;
            end else begin
               rdata_d = load_extract(mem_rdata, size_q, addr_q[1:0], uns_q);
               state_d = S_DONE;
            end
         end
         S_WR: begin
            rdata_d = '0;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready     = (state_q == S_IDLE);
   assign mem_read      = (state_q == S_RD);
   assign mem_write     = (state_q == S_WR);
   assign resp_valid    = (state_q == S_DONE) || (state_q == S_ERR);
   assign resp_misalign = (state_q == S_ERR);
   assign resp_rdata    = rdata_q;
   assign mem_addr      = {2'b00, addr_q[ADDR_W-1:2]};
   assign mem_wdata     = mem_wdata_q;

endmodule
